lcd1602_bus_if: RTL and testbench



---
 rtl/lcd1602_pkg.sv | 38 +++
 rtl/lcd1602_bus_if_delay_cnt.sv | 31 +++
 rtl/lcd1602_bus_if.sv | 175 +++++++++++++++++
 tb/tb_lcd1602_bus_if.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd1602_pkg.sv
// Shared types, instruction codes and default bus timing for the LCD1602 write port.
package lcd1602_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP = 3'd0,
    ST_IDLE  = 3'd1,
    ST_SETUP = 3'd2,
    ST_PULSE = 3'd3,
    ST_HOLD  = 3'd4,
    ST_EXEC  = 3'd5
  } lcd_state_e;

  localparam logic [7:0] FUNC_SET  = 8'h38;
  localparam logic [7:0] DISP_OFF  = 8'h08;
  localparam logic [7:0] CLEAR     = 8'h01;
  localparam logic [7:0] HOME      = 8'h02;
  localparam logic [7:0] ENTRY     = 8'h06;
  localparam logic [7:0] DISP_ON   = 8'h0C;
  localparam logic [7:0] ROW1_ADDR = 8'h80;
  localparam logic [7:0] ROW2_ADDR = 8'hC0;

  localparam int unsigned DEF_POWERUP_CYC   = 750000;
  localparam int unsigned DEF_SETUP_CYC     = 25;
  localparam int unsigned DEF_EN_HIGH_CYC   = 25;
  localparam int unsigned DEF_HOLD_CYC      = 10;
  localparam int unsigned DEF_EXEC_CYC      = 2000;
  localparam int unsigned DEF_EXEC_LONG_CYC = 80000;

  // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
  function automatic logic is_long_exec(input logic rs, input logic [7:0] data);
    return (rs == 1'b0) && (data[7:2] == 6'd0) && (data[1:0] != 2'd0);
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd1602_bus_if_delay_cnt.sv
// Loadable down-counter shared by every timing phase; saturates at zero.
module lcd1602_delay_cnt
  import lcd1602_pkg::*;
#(
  parameter int unsigned     W       = 20,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= RST_VAL;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
    end else begin
      count_q <= count_q;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/lcd1602_bus_if.sv
// HD44780 write-port stage: accepts one byte per handshake and owns all bus timing
// (power-up wait, setup, EN pulse, hold, execution delay).
module lcd1602_bus_if
  import lcd1602_pkg::*;
#(
  parameter int unsigned POWERUP_CYC   = DEF_POWERUP_CYC,
  parameter int unsigned SETUP_CYC     = DEF_SETUP_CYC,
  parameter int unsigned EN_HIGH_CYC   = DEF_EN_HIGH_CYC,
  parameter int unsigned HOLD_CYC      = DEF_HOLD_CYC,
  parameter int unsigned EXEC_CYC      = DEF_EXEC_CYC,
  parameter int unsigned EXEC_LONG_CYC = DEF_EXEC_LONG_CYC
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic       cmd_rs_i,
  input  logic [7:0] cmd_data_i,
  output logic       busy_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic       lcd_en_o,
  output logic [7:0] lcd_data_o
);

  localparam int unsigned MAX_CYC = max2(max2(max2(POWERUP_CYC, SETUP_CYC),
                                              max2(EN_HIGH_CYC, HOLD_CYC)),
                                         max2(EXEC_CYC, EXEC_LONG_CYC));
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  if ((POWERUP_CYC < 1) || (SETUP_CYC < 1) || (EN_HIGH_CYC < 1) ||
      (HOLD_CYC < 1) || (EXEC_CYC < 1) || (EXEC_LONG_CYC < 1)) begin : g_param_err
    $error("lcd1602_bus_if: every timing parameter must be >= 1");
  end

  lcd_state_e       state_q;
  logic             cmd_ready_q;
  logic             busy_q;
  logic             lcd_rs_q;
  logic             lcd_en_q;
  logic [7:0]       lcd_data_q;
  logic             long_q;

  logic             accept;
  logic             cnt_zero;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;

  assign accept = cmd_valid_i && cmd_ready_q;

  lcd1602_delay_cnt #(
    .W       (CNT_W),
    .RST_VAL (CNT_W'(POWERUP_CYC - 1))
  ) u_delay_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .zero_o     (cnt_zero)
  );

  // Each phase reloads the counter with the length of the phase it enters.
  always_comb begin
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(SETUP_CYC - 1);
        end else begin
          cnt_load     = 1'b0;
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(EN_HIGH_CYC - 1);
        end else begin
          cnt_load     = 1'b0;
        end
      end
      ST_PULSE: begin
        if (cnt_zero) begin
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(HOLD_CYC - 1);
        end else begin
          cnt_load     = 1'b0;
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          cnt_load     = 1'b1;
          cnt_load_val = long_q ? CNT_W'(EXEC_LONG_CYC - 1) : CNT_W'(EXEC_CYC - 1);
        end else begin
          cnt_load     = 1'b0;
        end
      end
      default: begin
        cnt_load     = 1'b0;
      end
    endcase
  end

  // Phase sequencing with every bus and handshake output registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_PWRUP;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b1;
      lcd_rs_q    <= 1'b0;
      lcd_en_q    <= 1'b0;
      lcd_data_q  <= 8'h00;
      long_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_PWRUP: begin
          if (cnt_zero) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (accept) begin
            state_q     <= ST_SETUP;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            lcd_rs_q    <= cmd_rs_i;
            lcd_data_q  <= cmd_data_i;
            long_q      <= is_long_exec(cmd_rs_i, cmd_data_i);
          end
        end
        ST_SETUP: begin
          if (cnt_zero) begin
            state_q  <= ST_PULSE;
            lcd_en_q <= 1'b1;
          end
        end
        ST_PULSE: begin
          if (cnt_zero) begin
            state_q  <= ST_HOLD;
            lcd_en_q <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (cnt_zero) begin
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt_zero) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_PWRUP;
          cmd_ready_q <= 1'b0;
          busy_q      <= 1'b1;
          lcd_en_q    <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign busy_o      = busy_q;
  assign lcd_rs_o    = lcd_rs_q;
  assign lcd_rw_o    = 1'b0;
  assign lcd_en_o    = lcd_en_q;
  assign lcd_data_o  = lcd_data_q;

endmodule

// File: tb/tb_lcd1602_bus_if.sv
// Self-checking bench for lcd1602_bus_if using shortened timing parameters.
module tb_lcd1602_bus_if;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rs;
  logic [7:0] cmd_data;
  logic       busy;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [7:0] lcd_data;

  lcd1602_bus_if #(
    .POWERUP_CYC   (100),
    .SETUP_CYC     (3),
    .EN_HIGH_CYC   (4),
    .HOLD_CYC      (2),
    .EXEC_CYC      (10),
    .EXEC_LONG_CYC (50)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_rs_i    (cmd_rs),
    .cmd_data_i  (cmd_data),
    .busy_o      (busy),
    .lcd_rs_o    (lcd_rs),
    .lcd_rw_o    (lcd_rw),
    .lcd_en_o    (lcd_en),
    .lcd_data_o  (lcd_data)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: a transaction is described only by its accept edge and length.
  int         g        = 0;
  int         ready_at = 1 << 30;
  int         acc      = -1000;
  logic [7:0] m_data   = 8'h00;
  logic       m_rs     = 1'b0;
  logic       live     = 1'b0;
  logic       accepted = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%0h exp=%0h", name, g, act, exp);
    end
  endtask

  task automatic step();
    logic       long_cmd;
    logic       exp_ready;
    logic       exp_en;
    logic [12:0] exp_v;
    logic [12:0] act_v;
    accepted = 1'b0;
    @(posedge clk);
    g++;
    if (rst) begin
      ready_at = g + 100;
      acc      = -1000;
      m_data   = 8'h00;
      m_rs     = 1'b0;
      live     = 1'b1;
    end else if (cmd_valid && (ready_at < g)) begin
      acc      = g;
      m_data   = cmd_data;
      m_rs     = cmd_rs;
      long_cmd = (cmd_rs == 1'b0) && (cmd_data >= 8'd1) && (cmd_data <= 8'd3);
      ready_at = g + (long_cmd ? 59 : 19);
      accepted = 1'b1;
    end
    #1;
    if (live) begin
      exp_ready = (g >= ready_at);
      exp_en    = (g >= acc + 3) && (g < acc + 7);
      exp_v     = {exp_ready, ~exp_ready, m_rs, 1'b0, exp_en, m_data};
      act_v     = {cmd_ready, busy, lcd_rs, lcd_rw, lcd_en, lcd_data};
      chk("bus_state", int'(act_v), int'(exp_v));
    end
  endtask

  task automatic wait_accept(input string nm);
    logic ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (accepted) begin
        ok = 1'b1;
        break;
      end
    end
    chk(nm, int'(ok), 1);
  endtask

  // Observe one transaction from its accept edge while scrambling the idle inputs.
  task automatic measure(input logic er, input logic [7:0] ed, input int lat, input string nm);
    int rise = -1;
    int fall = -1;
    int rdy  = -1;
    for (int i = 0; i < 200; i++) begin
      cmd_data = 8'($urandom);
      cmd_rs   = 1'($urandom);
      step();
      if (lcd_en && rise < 0) rise = g - acc;
      if (!lcd_en && rise >= 0 && fall < 0) fall = g - acc;
      if (lcd_en) chk({nm, "_pulse_data"}, int'({lcd_rs, lcd_data}), int'({er, ed}));
      if (cmd_ready) begin
        rdy = g - acc;
        break;
      end
    end
    chk({nm, "_en_rise"}, rise, 3);
    chk({nm, "_en_fall"}, fall, 7);
    chk({nm, "_ready_lat"}, rdy, lat);
    chk({nm, "_data_kept"}, int'(lcd_data), int'(ed));
  endtask

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         lat;
  } vec_t;

  vec_t       tbl[10];
  logic [7:0] bytes[3];
  int         g0;
  int         en_seen;
  int         accs[3];
  int         idx;
  int         pulses;
  int         width;
  logic       prev_en;
  int         g_r;

  initial begin
    tbl[0] = '{1'b0, 8'h38, 19};
    tbl[1] = '{1'b0, 8'h01, 59};
    tbl[2] = '{1'b0, 8'h02, 59};
    tbl[3] = '{1'b0, 8'h03, 59};
    tbl[4] = '{1'b0, 8'h00, 19};
    tbl[5] = '{1'b0, 8'h06, 19};
    tbl[6] = '{1'b0, 8'h04, 19};
    tbl[7] = '{1'b1, 8'h01, 19};
    tbl[8] = '{1'b0, 8'hC0, 19};
    tbl[9] = '{1'b1, 8'h02, 19};
    bytes[0] = 8'h4C;
    bytes[1] = 8'h43;
    bytes[2] = 8'h44;

    rst       = 1'b1;
    cmd_valid = 1'b1;
    cmd_rs    = 1'b0;
    cmd_data  = 8'h38;
    repeat (3) step();
    chk("reset_outputs", int'({cmd_ready, busy, lcd_en, lcd_rs, lcd_data}), int'({1'b0, 1'b1, 1'b0, 1'b0, 8'h00}));

    // Power-up wait with cmd_valid already held high.
    rst     = 1'b0;
    g0      = g + 1;
    en_seen = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (lcd_en) en_seen++;
      if (accepted) break;
    end
    chk("pwrup_accept_edge", acc - g0, 100);
    chk("pwrup_no_en", en_seen, 0);
    cmd_valid = 1'b0;
    measure(1'b0, 8'h38, 19, "first");

    for (int t = 0; t < 10; t++) begin
      cmd_valid = 1'b1;
      cmd_rs    = tbl[t].rs;
      cmd_data  = tbl[t].data;
      wait_accept("table_accept");
      cmd_valid = 1'b0;
      measure(tbl[t].rs, tbl[t].data, tbl[t].lat, "table");
    end

    // Back-to-back stream "LCD" with cmd_valid held.
    cmd_valid = 1'b1;
    cmd_rs    = 1'b1;
    cmd_data  = bytes[0];
    idx       = 0;
    pulses    = 0;
    width     = 0;
    prev_en   = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (accepted && idx < 3) begin
        accs[idx] = g;
        idx++;
        if (idx == 3) cmd_valid = 1'b0;
        else cmd_data = bytes[idx];
      end
      if (lcd_en) begin
        if (!prev_en) pulses++;
        width++;
        if (pulses >= 1 && pulses <= 3) chk("stream_data", int'(lcd_data), int'(bytes[pulses-1]));
        else chk("stream_extra_pulse", pulses, 3);
      end else if (prev_en) begin
        chk("stream_en_width", width, 4);
        width = 0;
      end
      prev_en = lcd_en;
      if (idx == 3 && cmd_ready) break;
    end
    chk("stream_accepts", idx, 3);
    chk("stream_pulses", pulses, 3);
    chk("stream_gap1", accs[1] - accs[0], 20);
    chk("stream_gap2", accs[2] - accs[1], 20);

    // Reset in the middle of an EN pulse.
    cmd_valid = 1'b1;
    cmd_rs    = 1'b0;
    cmd_data  = 8'h06;
    wait_accept("midrst_accept");
    cmd_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (lcd_en) break;
      step();
    end
    chk("midrst_en_seen", int'(lcd_en), 1);
    rst = 1'b1;
    step();
    g_r = g;
    chk("midrst_outputs", int'({lcd_en, lcd_data, cmd_ready, busy}), int'({1'b0, 8'h00, 1'b0, 1'b1}));
    rst       = 1'b0;
    cmd_valid = 1'b1;
    cmd_data  = 8'h0C;
    wait_accept("midrst_reaccept");
    chk("midrst_pwrup_repeat", acc - g_r, 101);
    cmd_valid = 1'b0;
    measure(1'b0, 8'h0C, 19, "after_rst");

    // Random traffic against the model, biased toward the long-exec codes.
    for (int i = 0; i < 1500; i++) begin
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_rs    = 1'($urandom);
      cmd_data  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      rst       = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
